// File: rtl/date_counter.sv
// Day-of-month stage of a calendar chain: counts day ticks, wraps at month end, clamps on month change.
// Optional macro DATE_LEAP_YEAR_EN enables 29-day February when leap=1.
module date_counter #(
  parameter logic [4:0] RESET_DATE = 5'd1
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       load,
  input  logic       enable,
  input  logic [4:0] data,
  input  logic       hourCount,
  input  logic [3:0] month,
  input  logic       leap,
  output logic [4:0] date,
  output logic [4:0] databus,
  output logic       dateCount,
  output logic       loadErr
);

  logic [4:0] r_date = RESET_DATE;
  logic       r_dateCount = 1'b0;
  logic       r_loadErr = 1'b0;

  logic [4:0] w_lastDay;
  logic [4:0] w_feb;
  logic [4:0] w_date_nxt;
  logic       w_cnt_nxt;
  logic       w_err_nxt;
  logic       w_load_ok;

`ifdef DATE_LEAP_YEAR_EN
  assign w_feb = leap ? 5'd29 : 5'd28;
`else
  logic w_unused_leap;
  assign w_unused_leap = leap;
  assign w_feb = 5'd28;
`endif

  always_comb begin
    case (month)
      4'd4, 4'd6, 4'd9, 4'd11: w_lastDay = 5'd30;
      4'd2:                    w_lastDay = w_feb;
      default:                 w_lastDay = 5'd31;
    endcase
  end

  assign w_load_ok = (data != 5'd0) && (data <= w_lastDay);

  // Priority below clear: load, then day tick, then clamp after a month change.
  always_comb begin
    w_date_nxt = r_date;
    w_cnt_nxt  = 1'b0;
    w_err_nxt  = 1'b0;
    if (load) begin
      if (w_load_ok) w_date_nxt = data;
      else           w_err_nxt  = 1'b1;
    end else if (hourCount) begin
      if (r_date < w_lastDay) begin
        w_date_nxt = r_date + 5'd1;
      end else begin
        w_date_nxt = 5'd1;
        w_cnt_nxt  = 1'b1;
      end
    end else if (r_date > w_lastDay) begin
      w_date_nxt = w_lastDay;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      r_date      <= RESET_DATE;
      r_dateCount <= 1'b0;
      r_loadErr   <= 1'b0;
    end else begin
      r_date      <= w_date_nxt;
      r_dateCount <= w_cnt_nxt;
      r_loadErr   <= w_err_nxt;
    end
  end

  assign date      = r_date;
  assign dateCount = r_dateCount;
  assign loadErr   = r_loadErr;
  assign databus   = enable ? r_date : 5'd0;

endmodule

// File: tb/tb_date_counter.sv
// Scoreboard bench for date_counter: calendar-rule reference model, directed scenarios then random traffic.
module tb_date_counter;

  logic       clk = 1'b0;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic       enable = 1'b0;
  logic [4:0] data = 5'd0;
  logic       hourCount = 1'b0;
  logic [3:0] month = 4'd0;
  logic       leap = 1'b0;
  logic [4:0] date;
  logic [4:0] databus;
  logic       dateCount;
  logic       loadErr;

  localparam int RESET_VAL = 1;
`ifdef DATE_LEAP_YEAR_EN
  localparam bit LEAP_EN = 1'b1;
`else
  localparam bit LEAP_EN = 1'b0;
`endif

  date_counter dut (
    .clk(clk), .clear(clear), .load(load), .enable(enable), .data(data),
    .hourCount(hourCount), .month(month), .leap(leap), .date(date),
    .databus(databus), .dateCount(dateCount), .loadErr(loadErr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] d;
    logic       cnt;
    logic       err;
    logic [4:0] bus;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   mdate = RESET_VAL;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int days_in(input int m, input bit lp);
    int tbl[13] = '{31, 31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    if (m < 1 || m > 12) return 31;
    if (m == 2 && lp && LEAP_EN) return 29;
    return tbl[m];
  endfunction

  task automatic step(input bit c, input bit l, input int d, input bit hc,
                      input int m, input bit lp, input bit en);
    int   ld;
    exp_t e;
    @(negedge clk);
    clear = c; load = l; data = 5'(d); hourCount = hc;
    month = 4'(m); leap = lp; enable = en;
    ld = days_in(m, lp);
    e.cnt = 1'b0;
    e.err = 1'b0;
    if (c) mdate = RESET_VAL;
    else if (l) begin
      if (d >= 1 && d <= ld) mdate = d;
      else e.err = 1'b1;
    end else if (hc) begin
      if (mdate < ld) mdate = mdate + 1;
      else begin
        mdate = 1;
        e.cnt = 1'b1;
      end
    end else if (mdate > ld) mdate = ld;
    e.d   = 5'(mdate);
    e.bus = en ? 5'(mdate) : 5'd0;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("date", date, e.d);
        chk("dateCount", dateCount, e.cnt);
        chk("loadErr", loadErr, e.err);
        chk("databus", databus, e.bus);
      end
    end
  end

  initial begin : driver
    int m;
    #1;
    chk("powerup_date", date, RESET_VAL);
    chk("powerup_dateCount", dateCount, 0);
    chk("powerup_loadErr", loadErr, 0);

    // January run: 31 ticks from reset, wrap with a single carry
    step(1, 0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 31; i++) step(0, 0, 0, 1, 1, 0, 1);
    step(0, 0, 0, 0, 1, 0, 1);

    // April: reject 31 and 0, accept 30, then wrap
    step(0, 1, 31, 0, 4, 0, 1);
    step(0, 1, 0, 0, 4, 0, 1);
    step(0, 1, 30, 0, 4, 0, 1);
    step(0, 0, 0, 1, 4, 0, 1);
    step(0, 0, 0, 0, 4, 0, 1);

    // February 28 with leap set
    step(0, 1, 28, 0, 2, 1, 1);
    step(0, 0, 0, 1, 2, 1, 1);
    step(0, 0, 0, 1, 2, 1, 1);

    // Clamp on month change 1 -> 2
    step(0, 1, 31, 0, 1, 0, 1);
    step(0, 0, 0, 0, 2, 0, 1);
    step(0, 0, 0, 0, 2, 0, 1);

    // Load beats tick at month end
    step(0, 1, 31, 0, 1, 0, 1);
    step(0, 1, 15, 1, 1, 0, 1);

    // Clear beats wrap, databus gated off
    step(0, 1, 31, 0, 1, 0, 1);
    step(1, 0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);

    for (int i = 0; i < 2000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      m = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 12);
      step(r < 2, (r >= 2 && r < 14), $urandom_range(0, 31), $urandom_range(0, 2) != 0,
           m, $urandom_range(0, 1), $urandom_range(0, 1));
    end

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() > 0) chk("drain_timeout", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/date_counter.md
DATE_COUNTER -- requirements
Module: date_counter

Interface
REQ-001 The block SHALL run on one clock with a synchronous, active-high reset: the clock port is clk and the reset port is clear.
REQ-002 Parameter RESET_DATE, default 5'd1, SHALL set the date loaded on clear; legal values are 1..28.
REQ-003 Port clk, input, 1 bit, SHALL be the rising-edge clock.
REQ-004 Port clear, input, 1 bit, SHALL be the synchronous, active-high reset.
REQ-005 Port load, input, 1 bit, SHALL be the parallel-load strobe.
REQ-006 Port enable, input, 1 bit, SHALL be the databus output enable.
REQ-007 Port data, input, 5 bits, SHALL carry the date value to load.
REQ-008 Port hourCount, input, 1 bit, SHALL be the day tick (one-cycle pulse from the hour stage at 23->00).
REQ-009 Port month, input, 4 bits, SHALL carry the current month (1..12) from the downstream month stage.
REQ-010 Port leap, input, 1 bit, SHALL flag that the current year is a leap year.
REQ-011 Port date, output, 5 bits, SHALL be the registered day of month (1..31).
REQ-012 Port databus, output, 5 bits, SHALL equal date when enable=1 and 0 otherwise (combinational).
REQ-013 Port dateCount, output, 1 bit, SHALL be a registered one-cycle carry pulse to the month stage.
REQ-014 Port loadErr, output, 1 bit, SHALL be a registered one-cycle pulse flagging a rejected load.

Function
REQ-015 lastDay SHALL be combinational from month: 1,3,5,7,8,10,12 -> 31; 4,6,9,11 -> 30; 2 -> 28 (29 per REQ-030); month 0 or 13..15 -> 31.
REQ-016 Per-cycle priority SHALL be clear > load > hourCount > clamp > hold.
REQ-017 Load: when 1 <= data <= lastDay, date SHALL take data on the next edge, with dateCount=0 and loadErr=0.
REQ-018 Load rejection: when data=0 or data>lastDay, date SHALL hold and loadErr SHALL pulse high for exactly one cycle.
REQ-019 Tick, no wrap: hourCount=1 and date<lastDay SHALL give date+1 on the next edge, with dateCount=0.
REQ-020 Tick, wrap: hourCount=1 and date>=lastDay SHALL give date=1 on the next edge, with dateCount=1 in that same cycle, for exactly one cycle.
REQ-021 Clamp: with no load and no tick, date>lastDay (after a month change) SHALL set date=lastDay on the next edge, with no dateCount.
REQ-022 Load and hourCount in the same cycle: load SHALL win, the tick SHALL be dropped, and dateCount SHALL be 0.
REQ-023 Back-to-back hourCount pulses SHALL each advance date by one; there is no minimum spacing.
REQ-024 date SHALL never leave 1..31 from any reachable state.
REQ-025 Every state change SHALL occur on the rising edge of clk; the only combinational outputs are databus and lastDay decode.

Reset
REQ-026 When clear=1 at a clk edge, date SHALL become RESET_DATE and dateCount and loadErr SHALL become 0, regardless of load and hourCount.
REQ-027 A clear mid-wrap, in the same cycle as hourCount at lastDay, SHALL suppress dateCount.
REQ-028 Power-up (initial) values SHALL equal the reset values.

Configuration
REQ-029 Macro DATE_LEAP_YEAR_EN SHALL control leap-year support.
REQ-030 With DATE_LEAP_YEAR_EN defined, February lastDay SHALL be 29 when leap=1 and 28 when leap=0.
REQ-031 Without DATE_LEAP_YEAR_EN, February lastDay SHALL be 28, leap SHALL be ignored, and the port SHALL remain present.

Verification
REQ-032 clear, then month=1 and 31 hourCount pulses: date SHALL run 1..31 then 1, with dateCount high once, in the cycle date=1.
REQ-033 month=4, load data=31: date SHALL be unchanged and loadErr SHALL pulse once; load data=30 then tick: date SHALL be 1 and dateCount SHALL be 1.
REQ-034 month=2, date=28, leap=1, tick: date SHALL be 29 with macro defined, and 1 with dateCount=1 without it.
REQ-035 date=31, month changed 1->2 with leap=0 and no tick: date SHALL be 28 after one cycle, with dateCount=0.
REQ-036 Same cycle load=1 (data=15) and hourCount=1 at date=31, month=1: date SHALL be 15 and dateCount SHALL be 0.
REQ-037 Same cycle clear=1 and hourCount=1 at date=31, with RESET_DATE=1: date SHALL be 1, dateCount SHALL be 0, and enable=0 SHALL drive databus=0.
